// File: rtl/flt2int_param.sv
// Purpose: multi-cycle float {sign,exp,frac} to signed INT_W integer converter, truncate or round-nearest-even.
// Latency: Start-accepting edge through Done edge is S+3 cycles (S = shift count), 2 cycles for specials.
// Backpressure: Start is only accepted in IDLE/DONE; Start while Busy is ignored; Result is held while Done.
//
// Ports:
//   Clk, Reset       clock and synchronous active-high reset
//   Start, Mode      conversion request; Mode 0 = truncate, 1 = round-nearest-even
//   FltIn            {sign, exp[EXP_W], frac[MAN_W]} latched on the accepting edge
//   Busy, Done       Busy in PARSE/SHIFT/ROUND; Done level-high in DONE
//   Result           signed result, valid while Done
//   Overflow/Invalid/Inexact  exception flags, updated only on entry to DONE
module flt2int_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Mode,
  input  logic [EXP_W+MAN_W:0]   FltIn,
  output logic                   Busy,
  output logic                   Done,
  output logic [INT_W-1:0]       Result,
  output logic                   Overflow,
  output logic                   Invalid,
  output logic                   Inexact
);

  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  // two spare bits above the widest operand so rounding never wraps
  localparam int DW      = ((INT_W > MAN_W + 1) ? INT_W : MAN_W + 1) + 2;
  // right shifts beyond MAN_W+2 cannot change guard/sticky any further
  localparam int RSH_MAX = MAN_W + 2;
  localparam int LSH_MAX = (INT_W - 2 - MAN_W > 0) ? INT_W - 2 - MAN_W : 0;
  localparam int CW      = $clog2(((RSH_MAX > LSH_MAX) ? RSH_MAX : LSH_MAX) + 1);

  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    NEG_LIM = {{(DW-INT_W){1'b0}}, 1'b1, {(INT_W-1){1'b0}}};
  localparam logic [DW-1:0]    POS_LIM = NEG_LIM - {{(DW-1){1'b0}}, 1'b1};
  localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] ONE_I   = {{(INT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARSE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MAN_W-1:0]    frac_q, frac_d;
  logic                mode_q, mode_d;
  logic [DW-1:0]       mag_q, mag_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;
  logic                left_q, left_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [INT_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                inv_q, inv_d;
  logic                inx_q, inx_d;

  logic                rnd_up;
  logic [DW-1:0]       mag_r;
  int                  e_val;
  int                  sh_val;

  // round-nearest-even: round up on guard when anything below it is set or the result is odd
  assign rnd_up = mode_q & guard_q & (sticky_q | mag_q[0]);
  assign mag_r  = mag_q + {{(DW-1){1'b0}}, rnd_up};

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    mode_d   = mode_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    left_d   = left_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    inx_d    = inx_q;
    e_val    = int'(exp_q) - BIAS;
    sh_val   = 0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_PARSE;
          sign_d  = FltIn[EXP_W+MAN_W];
          exp_d   = FltIn[EXP_W+MAN_W-1:MAN_W];
          frac_d  = FltIn[MAN_W-1:0];
          mode_d  = Mode;
        end
      end

      S_PARSE: begin
        if (&exp_q) begin
          state_d = S_DONE;
          inx_d   = 1'b0;
          if (|frac_q) begin
            result_d = '0;
            ovf_d    = 1'b0;
            inv_d    = 1'b1;
          end else begin
            result_d = sign_q ? SAT_NEG : SAT_POS;
            ovf_d    = 1'b1;
            inv_d    = 1'b0;
          end
        end else if (~|exp_q) begin
          // zero or subnormal: magnitude is below one
          state_d  = S_DONE;
          result_d = '0;
          ovf_d    = 1'b0;
          inv_d    = 1'b0;
          inx_d    = |frac_q;
        end else if (e_val > INT_W - 2) begin
          state_d  = S_DONE;
          result_d = sign_q ? SAT_NEG : SAT_POS;
          ovf_d    = 1'b1;
          inv_d    = 1'b0;
          inx_d    = 1'b0;
        end else begin
          mag_d    = {{(DW-MAN_W-1){1'b0}}, |exp_q, frac_q};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          if (e_val >= MAN_W) begin
            left_d = 1'b1;
            sh_val = e_val - MAN_W;
          end else begin
            left_d = 1'b0;
            sh_val = (MAN_W - e_val > RSH_MAX) ? RSH_MAX : MAN_W - e_val;
          end
          cnt_d   = CW'(sh_val);
          state_d = (sh_val == 0) ? S_ROUND : S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[DW-2:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[DW-1:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d = S_DONE;
        inv_d   = 1'b0;
        // negative side can reach one step further than positive
        if ((!sign_q && (mag_r > POS_LIM)) || (sign_q && (mag_r > NEG_LIM))) begin
          result_d = sign_q ? SAT_NEG : SAT_POS;
          ovf_d    = 1'b1;
          inx_d    = 1'b0;
        end else begin
          result_d = sign_q ? (~mag_r[INT_W-1:0] + ONE_I) : mag_r[INT_W-1:0];
          ovf_d    = 1'b0;
          inx_d    = guard_q | sticky_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      frac_q   <= '0;
      mode_q   <= 1'b0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      mode_q   <= mode_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      inx_q    <= inx_d;
    end
  end

  assign Busy     = (state_q == S_PARSE) || (state_q == S_SHIFT) || (state_q == S_ROUND);
  assign Done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign Overflow = ovf_q;
  assign Invalid  = inv_q;
  assign Inexact  = inx_q;

endmodule

// File: doc/flt2int_param.md
Name: flt2int_param

Overview:
- Parametrised, multi-cycle IEEE-style float-to-signed-integer converter with a Start/Done handshake.
- Generalises the fixed half-precision-to-int16 converter to arbitrary exponent, mantissa and result widths.
- Adds selectable rounding (truncate or round-nearest-even) and IEEE-style exception flags.
- Sits beside the core as a slave accelerator: the core latches an operand, pulses Start, and reads Result once Done is high.

Parameters:
EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored fraction width (hidden bit restored internally)
INT_W, 16, two's-complement result width

Ports:
Clk  in  1  clock; all state changes on the rising edge
Reset  in  1  synchronous, active-high; clears all state
Start  in  1  conversion request, sampled only in IDLE or DONE
Mode  in  1  0 = truncate toward zero, 1 = round-nearest-even; latched with Start
FltIn  in  1+EXP_W+MAN_W  {sign, exp, frac}; latched with Start
Busy  out  1  high in PARSE/SHIFT/ROUND
Done  out  1  level; high in DONE until next accepted Start or Reset
Result  out  INT_W  signed integer; valid while Done
Overflow  out  1  saturation occurred (includes Inf)
Invalid  out  1  NaN input
Inexact  out  1  nonzero fraction bits discarded (not set on saturate/NaN)

Behaviour:
- Reset: state IDLE; Busy=0, Done=0, Result=0, all flags 0. Reset mid-conversion aborts the operation; outputs are cleared on the same edge.
- States: IDLE -> PARSE -> SHIFT (S cycles, S may be 0) -> ROUND -> DONE. Special cases go PARSE -> DONE.
- DONE plus Start goes to PARSE: Done drops, Result and flags are held until overwritten. In DONE without Start, the block stays in DONE.
- Start while Busy is ignored. FltIn and Mode are captured only on the accepting edge.
- PARSE: e = exp - bias; M = {|exp, frac}. Special cases are decided here:
  - exp all ones, frac≠0: Result=0, Invalid=1.
  - exp all ones, frac=0: saturate, Overflow=1.
  - e > INT_W-2: saturate, Overflow=1.
  - exp=0 (zero or subnormal): Result=0; Inexact = (frac≠0).
  - Saturation value: +(2^(INT_W-1)-1) if sign=0, -2^(INT_W-1) if sign=1.
- SHIFT: one bit per cycle.
  - e ≥ MAN_W: left shift, S = e-MAN_W; exact result.
  - e < MAN_W: right shift, S = min(MAN_W-e, MAN_W+2). Each shift moves the LSB into guard and ORs the old guard into sticky.
- ROUND:
  - Mode 1: increment magnitude if guard & (sticky | lsb). Mode 0: no increment.
  - Inexact = guard | sticky.
  - If magnitude exceeds 2^(INT_W-1)-1 (positive) or 2^(INT_W-1) (negative), saturate, set Overflow=1, clear Inexact.
  - Otherwise negate if sign=1.
- Latency (Start-accepting edge to the edge raising Done): normal = S+3; special = 2.
- Internal datapath is max(INT_W, MAN_W+1)+2 bits; no intermediate truncation.
- Flags update only on entry to DONE.

Test Plan:
- Defaults, Mode=0, FltIn=0x3C00 (1.0) -> Result=0x0001, Inexact=0, Done 13 cycles after Start (S=10); Busy high for the preceding cycles.
- FltIn=0x3E00 (1.5): Mode=0 -> 1, Inexact=1; Mode=1 -> 2. FltIn=0x4100 (2.5), Mode=1 -> 2. FltIn=0xC100 (-2.5), Mode=1 -> 0xFFFE, Inexact=1.
- FltIn=0x7380 (15360.0) -> 0x3C00, Inexact=0, latency 6. FltIn=0xF380 -> 0xC400.
- Saturation and specials, each latency 2:
  - 0x7B80 -> 0x7FFF, Overflow=1; 0xFB80 -> 0x8000, Overflow=1.
  - 0x7C00 (+Inf) -> 0x7FFF, Overflow=1.
  - 0x7C01 (NaN) -> 0x0000, Invalid=1.
  - 0x0001 (subnormal) -> 0x0000, Inexact=1; 0x8000 -> 0x0000, no flags.
- Handshake:
  - Second Start pulse during SHIFT is ignored; the first result is unchanged.
  - Start held high through DONE starts back-to-back conversions, with Done low for exactly one PARSE cycle minimum.
  - Reset asserted mid-SHIFT -> next edge IDLE, Done=0, Result=0.
- Parameter sweep EXP_W=8, MAN_W=23, INT_W=32: 0x4B000000 (8388608.0) -> 0x00800000; 0x4F000000 (2^31) -> 0x7FFFFFFF, Overflow=1.
